xinput_port: RTL

- Memory-mapped input peripheral that sits behind the address decoder as the responder for the button/switch address windows.
- Synchronizes and debounces one push-button and an 8-bit switch bank.
- Latches button press events (sticky flag plus wrapping counter).
- Returns register data combinationally on the read port while selected, so the decoder mux can forward it in the same cycle.

---
 rtl/xinput_port_pkg.sv | 12 +
 rtl/xinput_port_xdebounce.sv | 36 +++
 rtl/xinput_port.sv | 70 +++++++
 3 files changed

// File: rtl/xinput_port_pkg.sv
// xinput_port_pkg: register offsets, CTRL bit positions and debounce defaults for xinput_port.
package xinput_port_pkg;
    localparam logic [1:0] XINPUT_STATUS  = 2'd0;
    localparam logic [1:0] XINPUT_SW      = 2'd1;
    localparam logic [1:0] XINPUT_EVT_CNT = 2'd2;
    localparam logic [1:0] XINPUT_CTRL    = 2'd3;
    localparam int CTRL_CLR_FLAG = 0;
    localparam int CTRL_CLR_CNT  = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int XINPUT_DEB_DEFAULT = 1000000;
    localparam int XINPUT_DEB_SIM     = 4;
endpackage

// File: rtl/xinput_port_xdebounce.sv
// xdebounce: 2-flop synchronizer plus stability counter for one raw input bit.
module xdebounce #(
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_CNT_W  = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o
);
    logic s1_q, s2_q, stable_q, stable_d, pend, last;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        pend     = s2_q != stable_q;
        last     = cnt_q == DEB_CNT_W'(DEB_CYCLES - 1);
        stable_d = (pend & last) ? s2_q : stable_q;
        cnt_d    = (pend & ~last) ? cnt_q + 1'b1 : '0;
    end
    // rise fires on the same edge the stable level flips so the event logic sees it immediately
    assign rise_o   = pend & last & s2_q;
    assign stable_o = stable_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/xinput_port.sv
// xinput_port: debounced button/switch peripheral with sticky press flag and press counter.
// Optional irq output and CTRL irq enable when XINPUT_IRQ_EN is defined.
module xinput_port
    import xinput_port_pkg::*;
#(
    parameter int DEB_CYCLES = XINPUT_DEB_DEFAULT,
    parameter int DEB_CNT_W  = 20,
    parameter int SW_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sel,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [31:0]     data_in,
    output logic [31:0]     data_to_rd,
    input  logic            btn_pad,
    input  logic [SW_W-1:0] sw_pad
`ifdef XINPUT_IRQ_EN
    ,
    output logic            irq
`endif
);
    logic [SW_W:0] raw, stable, rise;
    logic          evt_flag_q, evt_flag_d, irq_en_q, irq_en_d, ctrl_wr;
    logic [7:0]    evt_cnt_q, evt_cnt_d;
    logic [31:0]   status;
    logic          unused;
    assign raw = {sw_pad, btn_pad};
    genvar i;
    for (i = 0; i <= SW_W; i++) begin : g_deb
        xdebounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_CNT_W(DEB_CNT_W)) u_deb (
            .clk(clk), .rst(rst), .raw_i(raw[i]), .stable_o(stable[i]), .rise_o(rise[i])
        );
    end
    assign unused = &{1'b0, data_in[31:2], rise[SW_W:1]};
    assign ctrl_wr = sel & we & (addr == XINPUT_CTRL);
    // a press on the same edge as a clear wins, leaving flag=1 and count=1
    always_comb begin
        evt_flag_d = rise[0] ? 1'b1 : (ctrl_wr & data_in[CTRL_CLR_FLAG]) ? 1'b0 : evt_flag_q;
        evt_cnt_d  = (ctrl_wr & data_in[CTRL_CLR_CNT]) ? {7'd0, rise[0]} : evt_cnt_q + {7'd0, rise[0]};
`ifdef XINPUT_IRQ_EN
        irq_en_d   = ctrl_wr ? data_in[CTRL_IRQ_EN] : irq_en_q;
`else
        irq_en_d   = 1'b0;
`endif
        status     = {29'd0, irq_en_q, evt_flag_q, stable[0]};
    end
    assign data_to_rd = ~(sel & ~we)             ? 32'd0 :
                        (addr == XINPUT_STATUS)  ? status :
                        (addr == XINPUT_SW)      ? 32'(stable[SW_W:1]) :
                        (addr == XINPUT_EVT_CNT) ? {24'd0, evt_cnt_q} : 32'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_flag_q <= 1'b0;
            evt_cnt_q  <= 8'd0;
            irq_en_q   <= 1'b0;
        end else begin
            evt_flag_q <= evt_flag_d;
            evt_cnt_q  <= evt_cnt_d;
            irq_en_q   <= irq_en_d;
        end
    end
`ifdef XINPUT_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= evt_flag_q & irq_en_q;
    end
`endif
endmodule
